// File: rtl/event_encoder_4x2_pkg.sv
// Shared constants and helpers for the event encoder.
//   clog2    : ceiling log2, used to size index codes
//   popcount : number of set bits in a vector of up to 32 bits
package enc_pkg;

    localparam int unsigned NUM_IN_DEF     = 4;
    localparam int unsigned CODE_W_DEF     = 2;
    localparam int unsigned DROP_CNT_W_DEF = 4;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                c++;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/event_encoder_4x2_if.sv
// Code-based valid/ready output channel of the event encoder.
//   out_code  : binary index of the emitted event
//   out_valid : out_code holds an event
//   out_ready : consumer accepts when out_valid & out_ready
// master = encoder side, slave = consumer side.
interface event_encoder_4x2_if
    import enc_pkg::*;
#(
    parameter int unsigned CODE_W = CODE_W_DEF
) ();

    logic [CODE_W-1:0] out_code;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_code,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_code,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/prio_enc_comb.sv
// Combinational fixed-priority encoder.
//   in  : request vector
//   idx : index of the highest set bit (0 when none set)
//   any : |in
module prio_enc_comb #(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned CODE_W = 2
) (
    input  logic [NUM_IN-1:0] in,
    output logic [CODE_W-1:0] idx,
    output logic              any
);

    // Ascending scan: the last hit wins, so the highest set bit is reported.
    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (in[i]) begin
                idx = CODE_W'(i);
            end
        end
    end

    assign any = |in;

endmodule

// File: rtl/event_encoder_4x2.sv
// Event encoder: captures single-cycle pulses on NUM_IN request lines as pending
// bits and emits each one as a binary index code over a valid/ready channel,
// highest index first. Events re-raised while still pending are counted as drops.
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset
//   req      : event pulses, any number per cycle
//   clr_ovf  : synchronous clear of ovf and drop_cnt
//   busy     : events pending or a code on the output
//   ovf      : sticky, at least one event dropped
//   drop_cnt : saturating dropped-event count
//   out_if   : code/valid/ready output channel (master side)
module event_encoder_4x2
    import enc_pkg::*;
#(
    parameter int unsigned NUM_IN     = NUM_IN_DEF,
    parameter int unsigned CODE_W     = CODE_W_DEF,
    parameter int unsigned DROP_CNT_W = DROP_CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_IN-1:0]     req,
    input  logic                  clr_ovf,
    output logic                  busy,
    output logic                  ovf,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    event_encoder_4x2_if.master   out_if
);

    if (NUM_IN < 2 || NUM_IN > 32 || CODE_W != clog2(NUM_IN)) begin : g_bad_param
        $error("event_encoder_4x2: CODE_W must equal clog2(NUM_IN), 2 <= NUM_IN <= 32");
    end

    localparam logic [31:0] CntMax = (32'd1 << DROP_CNT_W) - 32'd1;

    logic [NUM_IN-1:0]     pend_q, pend_d;
    logic [NUM_IN-1:0]     take;
    logic [NUM_IN-1:0]     drop_vec;
    logic [CODE_W-1:0]     sel;
    logic                  pend_any;
    logic                  load;
    logic [CODE_W-1:0]     out_code_q;
    logic                  out_valid_q;
    logic                  ovf_q, ovf_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [31:0]           n_drop, cnt_base, cnt_sum;

    prio_enc_comb #(
        .NUM_IN (NUM_IN),
        .CODE_W (CODE_W)
    ) u_prio (
        .in  (pend_q),
        .idx (sel),
        .any (pend_any)
    );

    // Output register is free when empty or its current code is being accepted.
    assign load = ~out_valid_q | out_if.out_ready;

    always_comb begin
        take = '0;
        if (load && pend_any) begin
            take[sel] = 1'b1;
        end
    end

    // A request landing on the bit being taken starts a fresh event, not a drop.
    assign pend_d   = (pend_q & ~take) | req;
    assign drop_vec = req & pend_q & ~take;

    // Clear first, then add this cycle's drops, saturating at all-ones.
    always_comb begin
        n_drop     = 32'(popcount(32'(drop_vec)));
        cnt_base   = clr_ovf ? 32'd0 : 32'(drop_cnt_q);
        cnt_sum    = cnt_base + n_drop;
        drop_cnt_d = (cnt_sum > CntMax) ? CntMax[DROP_CNT_W-1:0] : cnt_sum[DROP_CNT_W-1:0];
        ovf_d      = (ovf_q & ~clr_ovf) | (n_drop != 32'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q      <= '0;
            out_code_q  <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
            if (load) begin
                if (pend_any) begin
                    out_code_q  <= sel;
                    out_valid_q <= 1'b1;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

    assign out_if.out_code  = out_code_q;
    assign out_if.out_valid = out_valid_q;
    assign busy             = (|pend_q) | out_valid_q;
    assign ovf              = ovf_q;
    assign drop_cnt         = drop_cnt_q;

endmodule

// File: tb/tb_event_encoder_4x2.sv
// Self-checking bench for event_encoder_4x2: directed scenarios plus a random
// phase, all outputs compared each cycle against a behavioural model.
module tb_event_encoder_4x2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       clr_ovf;
    logic       busy;
    logic       ovf;
    logic [3:0] drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: pending events, output register, drop bookkeeping.
    bit m_pend [4];
    bit m_valid;
    int m_code;
    int m_cnt;
    bit m_ovf;

    event_encoder_4x2_if #(.CODE_W(2)) bus ();

    event_encoder_4x2 #(
        .NUM_IN     (4),
        .CODE_W     (2),
        .DROP_CNT_W (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .clr_ovf  (clr_ovf),
        .busy     (busy),
        .ovf      (ovf),
        .drop_cnt (drop_cnt),
        .out_if   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
        m_valid = 1'b0;
        m_code  = 0;
        m_cnt   = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic compare_all(input string tag);
        bit any_pend;
        any_pend = 1'b0;
        for (int i = 0; i < 4; i++) any_pend |= m_pend[i];
        check({tag, ".valid"}, 32'(bus.out_valid), 32'(m_valid));
        check({tag, ".code"}, 32'(bus.out_code), 32'(m_code));
        check({tag, ".busy"}, 32'(busy), 32'(any_pend | m_valid));
        check({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
        check({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_cnt));
    endtask

    // Drive one cycle of inputs, advance the model by the same edge, compare.
    task automatic step(input logic [3:0] r, input logic rdy, input logic clr, input string tag);
        int sel;
        int nd;
        bit load;
        bit take [4];
        req           = r;
        bus.out_ready = rdy;
        clr_ovf       = clr;
        sel = -1;
        for (int i = 0; i < 4; i++) if (m_pend[i]) sel = i;
        load = !m_valid || rdy;
        for (int i = 0; i < 4; i++) take[i] = 1'b0;
        if (load && sel >= 0) take[sel] = 1'b1;
        nd = 0;
        for (int i = 0; i < 4; i++) if (r[i] && m_pend[i] && !take[i]) nd++;
        for (int i = 0; i < 4; i++) m_pend[i] = (m_pend[i] && !take[i]) || r[i];
        if (clr) begin
            m_cnt = 0;
            m_ovf = 1'b0;
        end
        m_cnt = (m_cnt + nd > 15) ? 15 : m_cnt + nd;
        if (nd > 0) m_ovf = 1'b1;
        if (load) begin
            if (sel >= 0) begin
                m_code  = sel;
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        compare_all(tag);
        req     = 4'b0000;
        clr_ovf = 1'b0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        check({tag, ".valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".code"}, 32'(bus.out_code), 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".ovf"}, 32'(ovf), 32'd0);
        check({tag, ".drop_cnt"}, 32'(drop_cnt), 32'd0);
        model_reset();
        #1 rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (busy && n < 20) begin
            step(4'b0000, 1'b1, 1'b0, tag);
            n++;
        end
        check({tag, ".drained"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [3:0] onehot;
        rst           = 1'b1;
        req           = 4'b0000;
        clr_ovf       = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();
        #12 rst = 1'b0;
        compare_all("post_reset");

        // Reset mid-stream with pend=1010 and a code on the output.
        step(4'b1010, 1'b0, 1'b0, "rst_a");
        step(4'b0000, 1'b0, 1'b0, "rst_b");
        step(4'b1000, 1'b0, 1'b0, "rst_c");
        check("rst_pre_valid", 32'(bus.out_valid), 32'd1);
        do_reset("rst_mid");

        // Single event: code 2 valid for exactly one cycle, two edges after req.
        step(4'b0100, 1'b1, 1'b0, "single_0");
        check("single_lat1", 32'(bus.out_valid), 32'd0);
        step(4'b0000, 1'b1, 1'b0, "single_1");
        check("single_code", 32'(bus.out_code), 32'd2);
        check("single_valid", 32'(bus.out_valid), 32'd1);
        step(4'b0000, 1'b1, 1'b0, "single_2");
        check("single_done", 32'(bus.out_valid), 32'd0);

        // Burst: 3,2,1,0 back to back.
        step(4'b1111, 1'b1, 1'b0, "burst_req");
        for (int k = 3; k >= 0; k--) begin
            step(4'b0000, 1'b1, 1'b0, "burst");
            check("burst_code", 32'(bus.out_code), 32'(k));
            check("burst_valid", 32'(bus.out_valid), 32'd1);
        end
        step(4'b0000, 1'b1, 1'b0, "burst_end");
        check("burst_idle", 32'(bus.out_valid), 32'd0);

        // Backpressure: code 1 held while ready low, then 0.
        step(4'b0011, 1'b0, 1'b0, "bp_req");
        for (int k = 0; k < 5; k++) begin
            step(4'b0000, 1'b0, 1'b0, "bp_hold");
            check("bp_held_code", 32'(bus.out_code), 32'd1);
        end
        step(4'b0000, 1'b1, 1'b0, "bp_rel");
        check("bp_next_code", 32'(bus.out_code), 32'd0);
        step(4'b0000, 1'b1, 1'b0, "bp_end");
        check("bp_idle", 32'(bus.out_valid), 32'd0);

        // Drops while stalled, clear, saturation, clear coinciding with a drop.
        step(4'b0001, 1'b0, 1'b0, "drop_a");
        step(4'b0001, 1'b0, 1'b0, "drop_b");
        check("drop_none_yet", 32'(drop_cnt), 32'd0);
        step(4'b0001, 1'b0, 1'b0, "drop_c");
        check("drop_cnt1", 32'(drop_cnt), 32'd1);
        check("drop_ovf1", 32'(ovf), 32'd1);
        step(4'b0000, 1'b0, 1'b1, "drop_clr");
        check("drop_cleared", 32'(drop_cnt), 32'd0);
        for (int k = 0; k < 20; k++) step(4'b0001, 1'b0, 1'b0, "drop_sat");
        check("drop_saturated", 32'(drop_cnt), 32'd15);
        step(4'b0001, 1'b0, 1'b1, "drop_clr_hit");
        check("clr_then_drop", 32'(drop_cnt), 32'd1);
        check("clr_then_ovf", 32'(ovf), 32'd1);
        step(4'b0000, 1'b0, 1'b1, "drop_clr2");
        drain("drop_drain");

        // Same-cycle re-raise on take: code 3 twice, no drop, decoder round trip.
        step(4'b1000, 1'b1, 1'b0, "same_a");
        for (int k = 0; k < 2; k++) begin
            step(k == 0 ? 4'b1000 : 4'b0000, 1'b1, 1'b0, "same_emit");
            check("same_code", 32'(bus.out_code), 32'd3);
            onehot = 4'b0001 << bus.out_code;
            check("same_roundtrip", 32'(onehot), 32'b1000);
        end
        check("same_no_drop", 32'(drop_cnt), 32'd0);
        step(4'b0000, 1'b1, 1'b0, "same_end");
        check("same_idle", 32'(bus.out_valid), 32'd0);

        // Random traffic with occasional clears and asynchronous resets.
        for (int k = 0; k < 600; k++) begin
            logic [3:0] r;
            r = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            step(r, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, "rand");
            if ($urandom_range(0, 149) == 0) do_reset("rand_rst");
        end
        drain("final_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
